// File: rtl/uart_point_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_point_frame_tx
// Description : Serialises N (H,V) centroids into one UART packet
//               (START, COUNT, payload, optional CHECKSUM, END) for uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_point_frame_tx #(
    parameter int         N_POINTS    = 16,
    parameter int         COORD_W     = 16,
    parameter logic [7:0] START_BYTE  = 8'h53,
    parameter logic [7:0] END_BYTE    = 8'h45,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [N_POINTS*COORD_W-1:0]  points_h,
    input  logic [N_POINTS*COORD_W-1:0]  points_v,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic                         tx_dv,
    output logic [7:0]                   tx_byte,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int c_BPC       = (COORD_W + 7) / 8;
    localparam int c_CW8       = c_BPC * 8;
    localparam int c_PAY_BYTES = 2 * N_POINTS * c_BPC;
    localparam int c_PAY_W     = c_PAY_BYTES * 8;
    localparam int c_FRAME_LEN = 3 + c_PAY_BYTES + (CHECKSUM_EN ? 1 : 0);
    localparam int c_IDX_W     = $clog2(c_FRAME_LEN);

    localparam logic [c_IDX_W-1:0] c_IDX_START = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_IDX_COUNT = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_PAY0  = c_IDX_W'(2);
    localparam logic [c_IDX_W-1:0] c_IDX_PEND  = c_IDX_W'(2 + c_PAY_BYTES);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_FRAME_LEN - 1);
    localparam logic [7:0]         c_COUNT     = 8'(N_POINTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_pending;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_chk;
    logic [c_PAY_W-1:0]   r_payload;
    logic [c_PAY_W-1:0]   w_payload_in;
    logic [7:0]           w_cur_byte;
    logic                 w_in_payload;
    logic                 w_in_chk_range;
    logic                 w_byte_done;

    // Payload laid out in transmission order, first byte at the MSB end
    generate
        for (genvar k = 0; k < N_POINTS; k++) begin : g_pack
            assign w_payload_in[c_PAY_W-1-(2*k)*c_CW8 -: c_CW8]   = c_CW8'(points_h[k*COORD_W +: COORD_W]);
            assign w_payload_in[c_PAY_W-1-(2*k+1)*c_CW8 -: c_CW8] = c_CW8'(points_v[k*COORD_W +: COORD_W]);
        end
    endgenerate

    assign w_in_payload   = (r_idx >= c_IDX_PAY0)  && (r_idx < c_IDX_PEND);
    assign w_in_chk_range = (r_idx >= c_IDX_COUNT) && (r_idx < c_IDX_PEND);
    assign w_byte_done    = (r_state == S_WAIT) && tx_done;

    always_comb begin
        w_cur_byte = END_BYTE;
        if (r_idx == c_IDX_START) begin
            w_cur_byte = START_BYTE;
        end else if (r_idx == c_IDX_COUNT) begin
            w_cur_byte = c_COUNT;
        end else if (w_in_payload) begin
            w_cur_byte = r_payload[c_PAY_W-1 -: 8];
        end else if (CHECKSUM_EN && (r_idx == c_IDX_PEND)) begin
            w_cur_byte = r_chk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_dv       = 1'b0;
        tx_byte     = 8'h00;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start || continuous) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                busy    = 1'b1;
                tx_byte = w_cur_byte;
                if (!tx_active) begin
                    tx_dv       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy    = 1'b1;
                tx_byte = w_cur_byte;
                if (tx_done) begin
                    w_state_nxt = (r_idx == c_IDX_LAST) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = (r_pending || start || continuous) ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_chk     <= 8'h00;
            r_payload <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A START landing in DONE is consumed by the DONE->LOAD transition
            if (r_state == S_DONE) begin
                r_pending <= 1'b0;
            end else if (start && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_payload <= w_payload_in;
                r_chk     <= 8'h00;
                r_idx     <= '0;
            end else if (w_byte_done) begin
                r_idx <= r_idx + c_IDX_W'(1);
                if (w_in_chk_range) begin
                    r_chk <= r_chk + w_cur_byte;
                end
                if (w_in_payload) begin
                    r_payload <= r_payload << 8;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_point_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_point_frame_tx
// Description : Scoreboard bench for uart_point_frame_tx, default build plus
//               a 10-bit / 2-point / no-checksum build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_point_frame_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start0, cont0, start1, cont1;
    logic [255:0] ph0, pv0;
    logic [19:0]  ph1, pv1;
    logic         m_busy0, m_busy1, force_active0;
    logic         tx_active0, tx_active1, tx_done0, tx_done1;
    logic         tx_dv0, tx_dv1, busy0, busy1, frame_done0, frame_done1;
    logic [7:0]   tx_byte0, tx_byte1;

    int checks = 0;
    int errors = 0;
    int fd_cnt0 = 0;
    int fd_cnt1 = 0;
    int rx_cnt0 = 0;
    int rx_cnt1 = 0;
    logic [7:0] rx0 [0:127];
    logic [7:0] rx1 [0:127];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    assign tx_active0 = m_busy0 | force_active0;
    assign tx_active1 = m_busy1;

    always #5 clk = ~clk;

    uart_point_frame_tx dut0 (
        .clk(clk), .reset_n(rst_n), .start(start0), .continuous(cont0),
        .points_h(ph0), .points_v(pv0), .tx_active(tx_active0), .tx_done(tx_done0),
        .tx_dv(tx_dv0), .tx_byte(tx_byte0), .busy(busy0), .frame_done(frame_done0)
    );

    uart_point_frame_tx #(.N_POINTS(2), .COORD_W(10), .CHECKSUM_EN(1'b0)) dut1 (
        .clk(clk), .reset_n(rst_n), .start(start1), .continuous(cont1),
        .points_h(ph1), .points_v(pv1), .tx_active(tx_active1), .tx_done(tx_done1),
        .tx_dv(tx_dv1), .tx_byte(tx_byte1), .busy(busy1), .frame_done(frame_done1)
    );

    // uart_tx model for dut0: accept on TX_DV, TX_DONE ten cycles later
    initial begin : model0
        logic       sdv;
        logic [7:0] sb, exp_b;
        int         cnt;
        m_busy0 = 1'b0; tx_done0 = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            sdv = tx_dv0 && !tx_active0;
            sb  = tx_byte0;
            if (tx_dv0 && tx_active0) begin
                checks++; errors++;
                $display("FAIL d0_dv_while_active: tx_dv=1 while tx_active=1 at %0t", $time);
            end
            if (frame_done0) fd_cnt0++;
            @(posedge clk); #1;
            tx_done0 = 1'b0;
            if (!rst_n) begin
                m_busy0 = 1'b0; cnt = 0;
            end else if (m_busy0) begin
                cnt--;
                if (cnt == 0) begin tx_done0 = 1'b1; m_busy0 = 1'b0; end
            end else if (sdv) begin
                if (rx_cnt0 < 128) rx0[rx_cnt0] = sb;
                rx_cnt0++;
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL d0_byte: got %02h, expected no byte", sb);
                end else begin
                    exp_b = q0.pop_front();
                    if (sb !== exp_b) begin
                        errors++;
                        $display("FAIL d0_byte[%0d]: got %02h, expected %02h", rx_cnt0-1, sb, exp_b);
                    end
                end
                m_busy0 = 1'b1; cnt = 10;
            end
        end
    end

    initial begin : model1
        logic       sdv;
        logic [7:0] sb, exp_b;
        int         cnt;
        m_busy1 = 1'b0; tx_done1 = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            sdv = tx_dv1 && !tx_active1;
            sb  = tx_byte1;
            if (tx_dv1 && tx_active1) begin
                checks++; errors++;
                $display("FAIL d1_dv_while_active: tx_dv=1 while tx_active=1 at %0t", $time);
            end
            if (frame_done1) fd_cnt1++;
            @(posedge clk); #1;
            tx_done1 = 1'b0;
            if (!rst_n) begin
                m_busy1 = 1'b0; cnt = 0;
            end else if (m_busy1) begin
                cnt--;
                if (cnt == 0) begin tx_done1 = 1'b1; m_busy1 = 1'b0; end
            end else if (sdv) begin
                if (rx_cnt1 < 128) rx1[rx_cnt1] = sb;
                rx_cnt1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL d1_byte: got %02h, expected no byte", sb);
                end else begin
                    exp_b = q1.pop_front();
                    if (sb !== exp_b) begin
                        errors++;
                        $display("FAIL d1_byte[%0d]: got %02h, expected %02h", rx_cnt1-1, sb, exp_b);
                    end
                end
                m_busy1 = 1'b1; cnt = 10;
            end
        end
    end

    // Expected frame for the default build, from the values at LOAD time
    task automatic push_frame0(input logic [255:0] h, input logic [255:0] v);
        logic [7:0]  chk;
        logic [15:0] hk, vk;
        q0.push_back(8'h53);
        q0.push_back(8'h10);
        chk = 8'h10;
        for (int k = 0; k < 16; k++) begin
            hk = h[k*16 +: 16];
            vk = v[k*16 +: 16];
            q0.push_back(hk[15:8]); q0.push_back(hk[7:0]);
            q0.push_back(vk[15:8]); q0.push_back(vk[7:0]);
            chk = chk + hk[15:8] + hk[7:0] + vk[15:8] + vk[7:0];
        end
        q0.push_back(chk);
        q0.push_back(8'h45);
    endtask

    task automatic push_frame1(input logic [19:0] h, input logic [19:0] v);
        logic [9:0] hk, vk;
        q1.push_back(8'h53);
        q1.push_back(8'h02);
        for (int k = 0; k < 2; k++) begin
            hk = h[k*10 +: 10];
            vk = v[k*10 +: 10];
            q1.push_back({6'b0, hk[9:8]}); q1.push_back(hk[7:0]);
            q1.push_back({6'b0, vk[9:8]}); q1.push_back(vk[7:0]);
        end
        q1.push_back(8'h45);
    endtask

    task automatic pulse_start0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic pulse_start1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic wait_fd0(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_cnt0 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fd1(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_cnt1 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rx0(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_cnt0 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start0 = 1'b0; cont0 = 1'b0; start1 = 1'b0; cont1 = 1'b0;
        force_active0 = 1'b0;
        ph0 = '0; pv0 = '0; ph1 = '0; pv1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_dv0, tx_byte0, busy0, frame_done0} !== 11'h0) begin
            errors++;
            $display("FAIL reset_d0: dv/byte/busy/fd = %b/%02h/%b/%b, expected 0/00/0/0", tx_dv0, tx_byte0, busy0, frame_done0);
        end
        checks++;
        if ({tx_dv1, tx_byte1, busy1, frame_done1} !== 11'h0) begin
            errors++;
            $display("FAIL reset_d1: dv/byte/busy/fd = %b/%02h/%b/%b, expected 0/00/0/0", tx_dv1, tx_byte1, busy1, frame_done1);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        int         base;
        bit         ok;
        int         pos [9] = '{0, 1, 2, 3, 4, 5, 6, 66, 67};
        logic [7:0] val [9] = '{8'h53, 8'h10, 8'h01, 8'h23, 8'h04, 8'h56, 8'h00, 8'h8E, 8'h45};
        ph0 = '0; pv0 = '0;
        ph0[15:0] = 16'h0123;
        pv0[15:0] = 16'h0456;
        base = fd_cnt0; rx_cnt0 = 0;
        push_frame0(ph0, pv0);
        pulse_start0;
        checks++;
        if (tx_dv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle: tx_dv=%b busy=%b, expected tx_dv=0 busy=1", tx_dv0, busy0);
        end
        @(negedge clk);
        checks++;
        if (tx_dv0 !== 1'b1 || tx_byte0 !== 8'h53) begin
            errors++;
            $display("FAIL first_dv_latency: tx_dv=%b byte=%02h, expected 1/53", tx_dv0, tx_byte0);
        end
        wait_fd0(base + 1, 2000, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || fd_cnt0 != base + 1 || busy0 !== 1'b0 || q0.size() != 0 || rx_cnt0 != 68) begin
            errors++;
            $display("FAIL single_frame_end: frame_done=%0d bytes=%0d busy=%b left=%0d, expected 1/68/0/0",
                     fd_cnt0 - base, rx_cnt0, busy0, q0.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx0[pos[i]] !== val[i]) begin
                errors++;
                $display("FAIL frame_byte[%0d]: got %02h, expected %02h", pos[i], rx0[pos[i]], val[i]);
            end
        end
    endtask

    task automatic test_snapshot;
        int base;
        bit ok;
        for (int k = 0; k < 16; k++) begin
            ph0[k*16 +: 16] = 16'($urandom);
            pv0[k*16 +: 16] = 16'($urandom);
        end
        base = fd_cnt0; rx_cnt0 = 0;
        push_frame0(ph0, pv0);
        pulse_start0;
        wait_rx0(3, 200, ok);
        ph0 = {256{1'b1}};
        pv0 = {256{1'b1}};
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL snapshot_progress: bytes=%0d, expected at least 3", rx_cnt0);
        end
        wait_fd0(base + 1, 2000, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || q0.size() != 0 || rx_cnt0 != 68) begin
            errors++;
            $display("FAIL snapshot_end: bytes=%0d left=%0d, expected 68/0", rx_cnt0, q0.size());
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit ok;
        ph0 = '0; pv0 = '0;
        for (int k = 0; k < 16; k++) begin
            ph0[k*16 +: 16] = 16'(k * 257 + 3);
            pv0[k*16 +: 16] = 16'(16'hF000 - k);
        end
        base = fd_cnt0; rx_cnt0 = 0;
        push_frame0(ph0, pv0);
        push_frame0(ph0, pv0);
        pulse_start0;
        wait_rx0(5, 200, ok);
        for (int i = 0; i < 3; i++) begin
            pulse_start0;
            repeat (7) @(negedge clk);
        end
        wait_fd0(base + 2, 4000, ok);
        repeat (30) @(negedge clk);
        checks++;
        if (!ok || fd_cnt0 != base + 2 || busy0 !== 1'b0 || q0.size() != 0 || rx_cnt0 != 136) begin
            errors++;
            $display("FAIL back_to_back: frames=%0d bytes=%0d busy=%b left=%0d, expected 2/136/0/0",
                     fd_cnt0 - base, rx_cnt0, busy0, q0.size());
        end
    endtask

    task automatic test_tx_active_hold;
        int base;
        bit ok;
        bit bad;
        base = fd_cnt0; rx_cnt0 = 0; bad = 1'b0;
        force_active0 = 1'b1;
        push_frame0(ph0, pv0);
        pulse_start0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (tx_dv0 !== 1'b0 || tx_byte0 !== 8'h53) bad = 1'b1;
            if (i < 49) @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_active: tx_dv=%b byte=%02h during hold, expected 0/53 throughout", tx_dv0, tx_byte0);
        end
        @(posedge clk); #1 force_active0 = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_dv0 !== 1'b1) begin
            errors++;
            $display("FAIL release_dv: tx_dv=%b, expected 1", tx_dv0);
        end
        wait_fd0(base + 1, 2000, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || q0.size() != 0 || rx_cnt0 != 68) begin
            errors++;
            $display("FAIL hold_frame_end: bytes=%0d left=%0d, expected 68/0", rx_cnt0, q0.size());
        end
    endtask

    task automatic test_narrow_coord;
        int         base;
        bit         ok;
        logic [7:0] val [4] = '{8'h53, 8'h02, 8'h03, 8'hFF};
        ph1 = {10'h2A0, 10'h3FF};
        pv1 = {10'h001, 10'h155};
        base = fd_cnt1; rx_cnt1 = 0;
        push_frame1(ph1, pv1);
        pulse_start1;
        wait_fd1(base + 1, 500, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || rx_cnt1 != 11 || q1.size() != 0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL narrow_frame: bytes=%0d left=%0d busy=%b, expected 11/0/0", rx_cnt1, q1.size(), busy1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx1[i] !== val[i]) begin
                errors++;
                $display("FAIL narrow_byte[%0d]: got %02h, expected %02h", i, rx1[i], val[i]);
            end
        end
        checks++;
        if (rx1[10] !== 8'h45) begin
            errors++;
            $display("FAIL narrow_end: got %02h, expected 45", rx1[10]);
        end
    endtask

    task automatic test_continuous;
        int base;
        int n;
        ph1 = {10'h123, 10'h0AB};
        pv1 = {10'h3C0, 10'h011};
        base = fd_cnt1; rx_cnt1 = 0; n = 0;
        push_frame1(ph1, pv1);
        push_frame1(ph1, pv1);
        @(negedge clk) cont1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done1) begin
                n++;
                if (n == 2) begin cont1 = 1'b0; break; end
            end
        end
        cont1 = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (fd_cnt1 != base + 2 || rx_cnt1 != 22 || busy1 !== 1'b0 || q1.size() != 0) begin
            errors++;
            $display("FAIL continuous: frames=%0d bytes=%0d busy=%b left=%0d, expected 2/22/0/0",
                     fd_cnt1 - base, rx_cnt1, busy1, q1.size());
        end
    endtask

    task automatic test_reset_abort;
        int base;
        bit ok;
        bit bad;
        rx_cnt0 = 0; bad = 1'b0;
        push_frame0(ph0, pv0);
        push_frame0(ph0, pv0);
        pulse_start0;
        wait_rx0(20, 400, ok);
        pulse_start0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {tx_dv0, tx_byte0, busy0, frame_done0} !== 11'h0) begin
            errors++;
            $display("FAIL abort_outputs: dv/byte/busy/fd = %b/%02h/%b/%b, expected 0/00/0/0", tx_dv0, tx_byte0, busy0, frame_done0);
        end
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = fd_cnt0; rx_cnt0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || tx_dv0 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || rx_cnt0 != 0) begin
            errors++;
            $display("FAIL stale_pending: activity after reset, bytes=%0d busy=%b, expected none", rx_cnt0, busy0);
        end
        ph0[15:0] = 16'hBEEF;
        push_frame0(ph0, pv0);
        pulse_start0;
        wait_fd0(base + 1, 2000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || fd_cnt0 != base + 1 || q0.size() != 0 || rx0[0] !== 8'h53 || rx0[1] !== 8'h10) begin
            errors++;
            $display("FAIL restart_frame: frames=%0d left=%0d first=%02h %02h, expected 1/0/53 10",
                     fd_cnt0 - base, q0.size(), rx0[0], rx0[1]);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_snapshot;
        test_back_to_back;
        test_tx_active_hold;
        test_narrow_coord;
        test_continuous;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
